// File: rtl/req_ack_responder.sv
// Req/ack pulse responder: one-cycle ack ACK_LATENCY cycles after each accepted req, MIN_GAP spacing check.
// Define REQ_ACK_PIPELINED_EN to ack every req via a shift register (violating reqs are also acked).
module req_ack_responder #(
  parameter int ACK_LATENCY = 4,
  parameter int MIN_GAP     = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_count_o,
  output logic             err_gap_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLDOFF = 2'd2
  } state_e;

  localparam logic [7:0] LAT_M1 = 8'(ACK_LATENCY - 1);
  localparam logic [7:0] GAP_M1 = 8'(MIN_GAP - 1);

  state_e           state_q, state_d;
  logic [7:0]       gcnt_q, gcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fsm_ack_d;
  logic             ack_int;

  // gcnt holds k during cycle T+k; the FSM both times the ack and polices spacing.
  always_comb begin
    state_d   = state_q;
    gcnt_d    = gcnt_q;
    err_d     = err_q;
    fsm_ack_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          gcnt_d = 8'd1;
          if (ACK_LATENCY == 1) begin
            fsm_ack_d = 1'b1;
            state_d   = (MIN_GAP > 1) ? S_HOLDOFF : S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (req_i) err_d = 1'b1;
        gcnt_d = gcnt_q + 8'd1;
        if (gcnt_q == LAT_M1) begin
          fsm_ack_d = 1'b1;
          state_d   = (MIN_GAP > ACK_LATENCY) ? S_HOLDOFF : S_IDLE;
        end
      end
      S_HOLDOFF: begin
        if (req_i) err_d = 1'b1;
        gcnt_d = gcnt_q + 8'd1;
        if (gcnt_q == GAP_M1) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gcnt_d  = 8'd0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ack_int) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gcnt_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef REQ_ACK_PIPELINED_EN
  // Stage i is high in cycle T+1+i; the last stage is the ack.
  localparam logic [ACK_LATENCY-1:0] BUSY_MASK = {ACK_LATENCY{1'b1}} >> 1;

  logic [ACK_LATENCY-1:0] sr_q, sr_d;
  logic [ACK_LATENCY:0]   sr_ext;

  always_comb begin
    sr_ext = {sr_q, req_i};
    sr_d   = sr_ext[ACK_LATENCY-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign ack_int = sr_q[ACK_LATENCY-1];
  assign busy_o  = |(sr_q & BUSY_MASK);
`else
  logic ack_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ack_q <= 1'b0;
    else       ack_q <= fsm_ack_d;
  end

  assign ack_int = ack_q;
  assign busy_o  = (state_q == S_WAIT);
`endif

  assign ack_o        = ack_int;
  assign done_count_o = cnt_q;
  assign err_gap_o    = err_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder (ACK_LATENCY=4, MIN_GAP=8, CNT_W=8); cycle 0 follows reset release.
module tb_req_ack_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       ack;
  logic       busy;
  logic [7:0] cnt;
  logic       err;

  int checks   = 0;
  int failures = 0;

  logic       ack_h [0:63];
  logic       busy_h[0:63];
  logic       err_h [0:63];
  logic [7:0] cnt_h [0:63];

  always #5 clk = ~clk;

  req_ack_responder #(
    .ACK_LATENCY(4),
    .MIN_GAP    (8),
    .CNT_W      (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .ack_o       (ack),
    .busy_o      (busy),
    .done_count_o(cnt),
    .err_gap_o   (err)
  );

  // Outputs of cycle c are captured 1ns into c, before that cycle's inputs are applied.
  task automatic drive(input logic [63:0] rpat, input logic [63:0] spat, input int n);
    for (int c = 0; c < n; c++) begin
      ack_h[c]  = ack;
      busy_h[c] = busy;
      err_h[c]  = err;
      cnt_h[c]  = cnt;
      req = rpat[c];
      rst = spat[c];
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ack !== 1'b0)  begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (cnt !== 8'd0)  begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    checks++; if (err !== 1'b0)  begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    // req coincident with rst must be ignored
    rst = 1'b1;
    req = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 1'b0;
    drive('0, '0, 10);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (ack_h[c] !== 1'b0 || busy_h[c] !== 1'b0) begin
        failures++; $display("FAIL reset_prio cyc=%0d ack=%b busy=%b exp 0/0", c, ack_h[c], busy_h[c]);
      end
    end
  endtask

  task automatic test_single();
    logic [63:0] p;
    logic e;
    do_reset();
    p = '0; p[10] = 1'b1;
    drive(p, '0, 24);
    for (int c = 0; c < 24; c++) begin
      e = (c == 14);
      checks++; if (ack_h[c] !== e) begin failures++; $display("FAIL single_ack cyc=%0d got=%b exp=%b", c, ack_h[c], e); end
      e = (c >= 11 && c <= 13);
      checks++; if (busy_h[c] !== e) begin failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", c, busy_h[c], e); end
    end
    checks++; if (cnt_h[14] !== 8'd0) begin failures++; $display("FAIL single_cnt14 got=%0d exp=0", cnt_h[14]); end
    checks++; if (cnt_h[15] !== 8'd1) begin failures++; $display("FAIL single_cnt15 got=%0d exp=1", cnt_h[15]); end
    checks++; if (err_h[23] !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err_h[23]); end
  endtask

  task automatic test_spacing();
    logic [63:0] p;
    logic e;
    do_reset();
    p = '0; p[10] = 1'b1; p[18] = 1'b1;
    drive(p, '0, 32);
    for (int c = 0; c < 32; c++) begin
      e = (c == 14 || c == 22);
      checks++; if (ack_h[c] !== e) begin failures++; $display("FAIL spacing_ack cyc=%0d got=%b exp=%b", c, ack_h[c], e); end
    end
    for (int c = 19; c <= 22; c++) begin
      e = (c != 22);
      checks++; if (busy_h[c] !== e) begin failures++; $display("FAIL spacing_busy cyc=%0d got=%b exp=%b", c, busy_h[c], e); end
    end
    checks++; if (cnt_h[31] !== 8'd2) begin failures++; $display("FAIL spacing_cnt got=%0d exp=2", cnt_h[31]); end
    checks++; if (err_h[31] !== 1'b0) begin failures++; $display("FAIL spacing_err got=%b exp=0", err_h[31]); end
  endtask

  task automatic test_violation();
    logic [63:0] p;
    logic e;
    logic [7:0] ecnt;
    do_reset();
    p = '0; p[10] = 1'b1; p[15] = 1'b1; p[18] = 1'b1;
    drive(p, '0, 32);
    for (int c = 0; c < 32; c++) begin
`ifdef REQ_ACK_PIPELINED_EN
      e = (c == 14 || c == 19 || c == 22);
`else
      e = (c == 14 || c == 22);
`endif
      checks++; if (ack_h[c] !== e) begin failures++; $display("FAIL viol_ack cyc=%0d got=%b exp=%b", c, ack_h[c], e); end
    end
`ifdef REQ_ACK_PIPELINED_EN
    ecnt = 8'd3;
`else
    ecnt = 8'd2;
`endif
    checks++; if (err_h[15] !== 1'b0) begin failures++; $display("FAIL viol_err15 got=%b exp=0", err_h[15]); end
    checks++; if (err_h[16] !== 1'b1) begin failures++; $display("FAIL viol_err16 got=%b exp=1", err_h[16]); end
    checks++; if (err_h[31] !== 1'b1) begin failures++; $display("FAIL viol_err_sticky got=%b exp=1", err_h[31]); end
    checks++; if (cnt_h[31] !== ecnt) begin failures++; $display("FAIL viol_cnt got=%0d exp=%0d", cnt_h[31], ecnt); end
  endtask

  task automatic test_gap_edge();
    logic [63:0] p;
    logic e;
    do_reset();
    p = '0; p[10] = 1'b1; p[17] = 1'b1;
    drive(p, '0, 32);
    for (int c = 0; c < 32; c++) begin
`ifdef REQ_ACK_PIPELINED_EN
      e = (c == 14 || c == 21);
`else
      e = (c == 14);
`endif
      checks++; if (ack_h[c] !== e) begin failures++; $display("FAIL gap7_ack cyc=%0d got=%b exp=%b", c, ack_h[c], e); end
    end
    checks++; if (err_h[17] !== 1'b0) begin failures++; $display("FAIL gap7_err17 got=%b exp=0", err_h[17]); end
    checks++; if (err_h[18] !== 1'b1) begin failures++; $display("FAIL gap7_err18 got=%b exp=1", err_h[18]); end
  endtask

  task automatic test_hold();
    logic [63:0] p;
    logic e;
    logic [7:0] ecnt;
    do_reset();
    p = '0; p[10] = 1'b1; p[11] = 1'b1;
    drive(p, '0, 24);
    for (int c = 0; c < 24; c++) begin
`ifdef REQ_ACK_PIPELINED_EN
      e = (c == 14 || c == 15);
`else
      e = (c == 14);
`endif
      checks++; if (ack_h[c] !== e) begin failures++; $display("FAIL hold_ack cyc=%0d got=%b exp=%b", c, ack_h[c], e); end
    end
`ifdef REQ_ACK_PIPELINED_EN
    ecnt = 8'd2;
`else
    ecnt = 8'd1;
`endif
    checks++; if (err_h[11] !== 1'b0) begin failures++; $display("FAIL hold_err11 got=%b exp=0", err_h[11]); end
    checks++; if (err_h[12] !== 1'b1) begin failures++; $display("FAIL hold_err12 got=%b exp=1", err_h[12]); end
    checks++; if (cnt_h[23] !== ecnt) begin failures++; $display("FAIL hold_cnt got=%0d exp=%0d", cnt_h[23], ecnt); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    logic [63:0] s;
    logic e;
    do_reset();
    p = '0; p[10] = 1'b1; p[20] = 1'b1;
    s = '0; s[12] = 1'b1;
    drive(p, s, 32);
    for (int c = 0; c < 32; c++) begin
      e = (c == 24);
      checks++; if (ack_h[c] !== e) begin failures++; $display("FAIL rstmid_ack cyc=%0d got=%b exp=%b", c, ack_h[c], e); end
    end
    checks++; if (busy_h[12] !== 1'b1) begin failures++; $display("FAIL rstmid_busy12 got=%b exp=1", busy_h[12]); end
    checks++; if (busy_h[13] !== 1'b0) begin failures++; $display("FAIL rstmid_busy13 got=%b exp=0", busy_h[13]); end
    checks++; if (err_h[13] !== 1'b0)  begin failures++; $display("FAIL rstmid_err13 got=%b exp=0", err_h[13]); end
    checks++; if (cnt_h[13] !== 8'd0)  begin failures++; $display("FAIL rstmid_cnt13 got=%0d exp=0", cnt_h[13]); end
    checks++; if (cnt_h[31] !== 8'd1)  begin failures++; $display("FAIL rstmid_cnt31 got=%0d exp=1", cnt_h[31]); end
  endtask

  // Reqs exactly MIN_GAP apart: all accepted, no error, counter wraps on the 256th ack.
  task automatic test_back_to_back_wrap();
    int acks;
    do_reset();
    acks = 0;
    for (int k = 0; k < 255; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (ack === 1'b1) acks++;
        req = (j == 0);
        @(posedge clk);
        #1;
      end
    end
    req = 1'b0;
    checks++; if (acks != 255)   begin failures++; $display("FAIL b2b_acks got=%0d exp=255", acks); end
    checks++; if (cnt !== 8'd255) begin failures++; $display("FAIL b2b_cnt255 got=%0d exp=255", cnt); end
    checks++; if (err !== 1'b0)   begin failures++; $display("FAIL b2b_err got=%b exp=0", err); end
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL b2b_wrap got=%0d exp=0", cnt); end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    test_reset();
    test_single();
    test_spacing();
    test_violation();
    test_gap_edge();
    test_hold();
    test_reset_mid();
    test_back_to_back_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_ack_responder.md
Name: req_ack_responder

Overview:
- Downstream responder for the single-cycle req/ack pulse protocol.
- Consumes req pulses and returns a one-cycle ack exactly ACK_LATENCY cycles after each accepted req.
- Enforces a minimum req spacing and flags violations; counts completed handshakes.
- Sits directly after the req-generating stage; its ack output drives that stage's ack input.

Parameters:
- ACK_LATENCY, 4: cycles from req-high cycle to ack-high cycle; legal range 1..15.
- MIN_GAP, 8: minimum cycles between accepted req pulses; must be >= ACK_LATENCY, max 255.
- CNT_W, 8: width of done_count.

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous reset, active-high
- req  input  1  request pulse, nominally one cycle high
- ack  output 1  registered acknowledge pulse, one cycle high
- busy  output 1  high while an accepted req awaits its ack
- done_count  output CNT_W  number of acks issued, wraps modulo 2^CNT_W
- err_gap  output 1  sticky: a req arrived inside the MIN_GAP window or was held high >1 cycle

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst high at posedge):
  - ack=0, busy=0, done_count=0, err_gap=0; FSM -> IDLE; counters cleared.
  - Any pending ack is cancelled.
  - rst has priority over req in the same cycle; that req is ignored.
- Timing reference: cycle T = the cycle in which req is high at the posedge ending it.
- FSM states IDLE, WAIT, HOLDOFF, with internal gap counter gcnt (8 bits):
  - IDLE: req=1 -> accept; gcnt<=1; WAIT.
  - WAIT: gcnt increments each cycle. When gcnt==ACK_LATENCY-1 at a posedge, ack<=1 for the next cycle, so ack is high in cycle T+ACK_LATENCY. Go to HOLDOFF if MIN_GAP>ACK_LATENCY, else IDLE.
  - ACK_LATENCY=1: ack is high in T+1 directly from IDLE.
  - HOLDOFF: gcnt increments. Leave to IDLE when gcnt reaches MIN_GAP-1, so req is acceptable in cycle T+MIN_GAP.
  - A req in cycle T+MIN_GAP, while the FSM is in IDLE, is accepted normally.
- busy:
  - 1 in cycles T+1 .. T+ACK_LATENCY-1.
  - 0 in the ack cycle and after.
  - busy and ack are never both 1.
- done_count increments by 1 at the posedge ending each ack cycle; wraps from 2^CNT_W-1 to 0.
- Violations (req in cycles T+1 .. T+MIN_GAP-1, in WAIT or HOLDOFF):
  - err_gap<=1, sticky until rst.
  - The violating req is ignored: it does not restart timing and produces no ack.
  - The pending ack is unaffected.
  - A req held high two consecutive cycles is a violation on the second cycle.
- A req coincident with an ack cycle is accepted only if the gap is satisfied (possible only when MIN_GAP==ACK_LATENCY); the ack for the previous req still issues.
- No combinational path from req to any output.

Optional Feature:
- Macro: REQ_ACK_PIPELINED_EN.
- Defined:
  - Replace the FSM ack timing with an ACK_LATENCY-deep shift register.
  - Every req-high cycle yields an ack exactly ACK_LATENCY cycles later, including violating ones.
  - err_gap detection is unchanged (still flags, still sticky).
  - busy = OR of shift-register stages 0..ACK_LATENCY-2.
  - done_count counts every ack.
- Undefined: behaviour as above; violating reqs are dropped.

Test Plan:
- Reset, then req at cycle 10 -> busy 11..13; ack high only in cycle 14; done_count 1 after cycle 14; err_gap 0.
- req at 10 and at 18 -> acks at 14 and 22; done_count 2; err_gap 0.
- req at 10 and at 15 -> ack only at 14, none at 19; err_gap=1 from cycle 16, stays 1; done_count 1. With REQ_ACK_PIPELINED_EN: acks at 14 and 19, done_count 2, err_gap=1.
- req held high cycles 10-11 -> single ack at 14; err_gap=1.
- req at 10, rst high in cycle 12 -> no ack at 14; all outputs 0 from cycle 13; req at 20 -> ack at 24.
- Preload 255 handshakes (CNT_W=8, reqs every 8 cycles) -> done_count 255; next ack -> done_count 0.
